// File: rtl/irq_context_ctrl.sv
// Interrupt context controller: selects the main/shadow register bank, records
// registers written by the ISR, and copies them back into the shadow bank after return.
module irq_context_ctrl #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64,
  localparam int AW        = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  irq_req,
  input  logic                  irq_ret,
  input  logic                  cpu_wr_en,
  input  logic [AW-1:0]         cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0] main_rd_data,
  output logic                  interrupt,
  output logic                  irq_ack,
  output logic                  stall,
  output logic [AW-1:0]         sync_rd_addr,
  output logic                  shadow_wr_en,
  output logic [AW-1:0]         shadow_wr_addr,
  output logic [DATA_WIDTH-1:0] shadow_wr_data
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ISR  = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [REG_NUM-1:0]   dirty_q, dirty_d;
  logic [REG_NUM-1:0]   wr_mask;
  logic [REG_NUM-1:0]   idx_mask;
  logic [AW-1:0]        idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
    end
  end

  // One-hot of the register the CPU writes this cycle; register 0 is never tracked.
  always_comb begin
    wr_mask = '0;
    if (cpu_wr_en && (cpu_wr_addr != '0)) wr_mask[cpu_wr_addr] = 1'b1;
  end

  // Lowest dirty index; scanning downward leaves the lowest set bit last.
  always_comb begin
    idx      = '0;
    idx_mask = '0;
    for (int i = REG_NUM - 1; i >= 0; i--) begin
      if (dirty_q[i]) idx = i[AW-1:0];
    end
    if (dirty_q != '0) idx_mask[idx] = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    dirty_d        = dirty_q;
    irq_ack        = 1'b0;
    interrupt      = 1'b0;
    stall          = 1'b0;
    sync_rd_addr   = '0;
    shadow_wr_en   = 1'b0;
    shadow_wr_addr = '0;
    shadow_wr_data = main_rd_data;
    unique case (state_q)
      ST_RUN: begin
        if (irq_req && reset) begin
          irq_ack = 1'b1;
          state_d = ST_ISR;
        end
      end
      ST_ISR: begin
        interrupt = 1'b1;
        dirty_d   = dirty_q | wr_mask;
        // A return always wins over a concurrent request; the request stays pending.
        if (irq_ret) state_d = (dirty_d != '0) ? ST_SYNC : ST_RUN;
      end
      ST_SYNC: begin
        stall          = 1'b1;
        sync_rd_addr   = idx;
        shadow_wr_addr = idx;
        // A CPU write to the same register already lands in both banks.
        shadow_wr_en   = !(cpu_wr_en && (cpu_wr_addr == idx));
        dirty_d        = dirty_q & ~idx_mask & ~wr_mask;
        if (dirty_d == '0) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        dirty_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_context_ctrl.sv
// Directed bench for irq_context_ctrl: entry/exit, dirty resync, writes during resync,
// pending requests, simultaneous return/request and reset in the middle of a resync.
module tb_irq_context_ctrl;
  localparam int REG_NUM    = 32;
  localparam int DATA_WIDTH = 64;
  localparam int AW         = $clog2(REG_NUM);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  irq_req;
  logic                  irq_ret;
  logic                  cpu_wr_en;
  logic [AW-1:0]         cpu_wr_addr;
  logic [DATA_WIDTH-1:0] main_rd_data;
  logic                  interrupt;
  logic                  irq_ack;
  logic                  stall;
  logic [AW-1:0]         sync_rd_addr;
  logic                  shadow_wr_en;
  logic [AW-1:0]         shadow_wr_addr;
  logic [DATA_WIDTH-1:0] shadow_wr_data;

  logic [DATA_WIDTH-1:0] main_mem [REG_NUM];
  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  // Main bank model: combinational read at the controller's read address.
  assign main_rd_data = main_mem[sync_rd_addr];

  irq_context_ctrl #(.REG_NUM(REG_NUM), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_ret(irq_ret),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .main_rd_data(main_rd_data),
    .interrupt(interrupt), .irq_ack(irq_ack), .stall(stall),
    .sync_rd_addr(sync_rd_addr), .shadow_wr_en(shadow_wr_en),
    .shadow_wr_addr(shadow_wr_addr), .shadow_wr_data(shadow_wr_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled 1 ns after the inputs settle, well before the next edge.
  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic en, input int addr);
    cpu_wr_en   = en;
    cpu_wr_addr = AW'(addr);
  endtask

  task automatic check_restore(input string tag, input int addr);
    check({tag, "_stall"}, 64'(stall), 64'd1);
    check({tag, "_wen"}, 64'(shadow_wr_en), 64'd1);
    check({tag, "_waddr"}, 64'(shadow_wr_addr), 64'(addr));
    check({tag, "_raddr"}, 64'(sync_rd_addr), 64'(addr));
    check({tag, "_wdata"}, shadow_wr_data, main_mem[addr]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_int"}, 64'(interrupt), 64'd0);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check({tag, "_wen"}, 64'(shadow_wr_en), 64'd0);
    check({tag, "_waddr"}, 64'(shadow_wr_addr), 64'd0);
    check({tag, "_raddr"}, 64'(sync_rd_addr), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < REG_NUM; i++) main_mem[i] = 64'h1000_0000_0000_0000 + 64'(i);
    main_mem[3]  = 64'hA5A5_A5A5_A5A5_A5A5;
    main_mem[5]  = 64'h1234_5678_9ABC_DEF0;
    main_mem[31] = 64'hDEAD_BEEF_CAFE_F00D;
    reset = 1'b0; irq_req = 1'b0; irq_ret = 1'b0; wr(1'b0, 0);

    // Reset held low for two edges.
    tick(); tick();
    settle();
    check_idle("rst");
    check("rst_ack", 64'(irq_ack), 64'd0);
    reset = 1'b1;

    // Basic entry/exit with no writes.
    irq_req = 1'b1; settle();
    check("t1_ack", 64'(irq_ack), 64'd1);
    check("t1_int_pre", 64'(interrupt), 64'd0);
    tick(); irq_req = 1'b0; settle();
    check("t1_int", 64'(interrupt), 64'd1);
    check("t1_ack_low", 64'(irq_ack), 64'd0);
    irq_ret = 1'b1;
    tick(); irq_ret = 1'b0; settle();
    check_idle("t1_ret");
    tick(); settle();
    check("t1_stall_after", 64'(stall), 64'd0);

    // Dirty resync: writes 5, 3, 31 and 0 (0 together with the return).
    irq_req = 1'b1;
    tick(); irq_req = 1'b0;
    wr(1'b1, 5);  tick();
    wr(1'b1, 3);  tick();
    wr(1'b1, 31); tick();
    wr(1'b1, 0);  irq_ret = 1'b1; tick();
    wr(1'b0, 0);  irq_ret = 1'b0; settle();
    check("t2_int", 64'(interrupt), 64'd0);
    check_restore("t2_r0", 3);
    tick(); settle(); check_restore("t2_r1", 5);
    tick(); settle(); check_restore("t2_r2", 31);
    tick(); settle(); check_idle("t2_end");

    // Write during SYNC: dirty {4,9}, 9 written in the return cycle.
    irq_req = 1'b1;
    tick(); irq_req = 1'b0;
    wr(1'b1, 4); tick();
    wr(1'b1, 9); irq_ret = 1'b1; tick();
    irq_ret = 1'b0; wr(1'b1, 4); settle();
    check("t3_stall0", 64'(stall), 64'd1);
    check("t3_wen0", 64'(shadow_wr_en), 64'd0);
    check("t3_raddr0", 64'(sync_rd_addr), 64'd4);
    tick(); wr(1'b0, 0); settle();
    check_restore("t3_r1", 9);
    tick(); settle(); check_idle("t3_end");

    // Request held through ISR and a two-register SYNC.
    irq_req = 1'b1;
    tick(); settle();
    check("t4_isr_ack", 64'(irq_ack), 64'd0);
    wr(1'b1, 7); tick();
    wr(1'b1, 8); irq_ret = 1'b1; tick();
    wr(1'b0, 0); irq_ret = 1'b0; settle();
    check("t4_s0_ack", 64'(irq_ack), 64'd0);
    check_restore("t4_r0", 7);
    tick(); settle();
    check("t4_s1_ack", 64'(irq_ack), 64'd0);
    check_restore("t4_r1", 8);
    tick(); settle();
    check("t4_run_stall", 64'(stall), 64'd0);
    check("t4_run_ack", 64'(irq_ack), 64'd1);
    tick(); irq_req = 1'b0; settle();
    check("t4_int2", 64'(interrupt), 64'd1);
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;

    // Simultaneous return and request in ISR.
    irq_req = 1'b1;
    tick(); settle();
    check("t5_isr", 64'(interrupt), 64'd1);
    irq_ret = 1'b1; settle();
    check("t5_both_ack", 64'(irq_ack), 64'd0);
    tick(); irq_ret = 1'b0; settle();
    check("t5_int_fall", 64'(interrupt), 64'd0);
    check("t5_stall", 64'(stall), 64'd0);
    check("t5_ack", 64'(irq_ack), 64'd1);
    tick(); irq_req = 1'b0; settle();
    check("t5_int_again", 64'(interrupt), 64'd1);
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;

    // Reset in the middle of a resync of {1,2,3}.
    irq_req = 1'b1;
    tick(); irq_req = 1'b0;
    wr(1'b1, 1); tick();
    wr(1'b1, 2); tick();
    wr(1'b1, 3); irq_ret = 1'b1; tick();
    wr(1'b0, 0); irq_ret = 1'b0; settle();
    check_restore("t6_r0", 1);
    tick(); reset = 1'b0; settle();
    check_restore("t6_r1", 2);
    tick(); reset = 1'b1; settle();
    check_idle("t6_rst");
    irq_req = 1'b1;
    tick(); irq_req = 1'b0; settle();
    check("t6_int", 64'(interrupt), 64'd1);
    irq_ret = 1'b1;
    tick(); irq_ret = 1'b0; settle();
    check_idle("t6_ret");
    tick(); settle();
    check("t6_no_sync", 64'(stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
